hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: MemRead_EX  in  1  EX-stage instruction is a load; rd_EX  in  5  its destination.
REQ-004 SHALL have ports: rs1_ID, rs2_ID  in  5 each  ID-stage sources; uses_rs2_ID  in  1  rs2 is a real operand.
REQ-005 SHALL have ports: branch_taken_EX  in  1  branch/jump resolved taken in EX.
REQ-006 SHALL have ports: mem_req_MEM  in  1  MEM-stage data access pending; mem_ready  in  1  data memory completes this cycle.
REQ-007 SHALL have ports: PCWrite, IF_ID_Write  out  1  register enables; ID_EX_bubble  out  1  insert NOP into ID/EX.
REQ-008 SHALL have ports: IF_ID_flush, ID_EX_flush  out  1  squash; pipe_freeze  out  1  hold all pipeline registers.
REQ-009 SHALL have ports: mem_timeout  out  1  sticky error; lu_stall_cnt, flush_cnt  out  16  perf counters.

Function
REQ-010 SHALL run FSM states RUN, MEM_WAIT, ERROR; encoding free.
REQ-011 SHALL define wait_cond = mem_req_MEM && !mem_ready; wait_cnt 8-bit register.
REQ-012 SHALL define load_use = MemRead_EX && rd_EX!=0 && (rd_EX==rs1_ID || (uses_rs2_ID && rd_EX==rs2_ID)).
REQ-013 SHALL drive all control outputs combinationally from state and inputs (zero latency); counters/state registered.
REQ-014 SHALL, when wait_cond in RUN or MEM_WAIT: pipe_freeze=1, PCWrite=0, IF_ID_Write=0, all flush/bubble=0 (freeze has highest priority).
REQ-015 SHALL, RUN without wait_cond and branch_taken_EX: IF_ID_flush=1, ID_EX_flush=1, PCWrite=1, ID_EX_bubble=0; branch wins over load_use.
REQ-016 SHALL, RUN without wait_cond, no branch, load_use: PCWrite=0, IF_ID_Write=0, ID_EX_bubble=1 for exactly that cycle.
REQ-017 SHALL otherwise drive PCWrite=1, IF_ID_Write=1, all others 0.
REQ-018 SHALL transition RUN->MEM_WAIT on wait_cond; MEM_WAIT->RUN when mem_ready=1 or mem_req_MEM=0; freeze drops in the mem_ready cycle.
REQ-019 SHALL clear wait_cnt whenever wait_cond=0 and increment it each wait_cond cycle; value during k-th consecutive wait cycle = k-1.
REQ-020 SHALL go to ERROR at the edge ending a wait_cond cycle with wait_cnt==255 (256 consecutive wait cycles).
REQ-021 SHALL in ERROR hold pipe_freeze=1, PCWrite=0, IF_ID_Write=0, mem_timeout=1 regardless of inputs until reset.
REQ-022 SHALL keep mem_timeout=0 in RUN and MEM_WAIT.

Reset
REQ-023 SHALL on rst_n=0 immediately set state RUN, wait_cnt=0, counters=0, mem_timeout=0, independent of clk.
REQ-024 SHALL apply reset mid-MEM_WAIT or in ERROR identically; first edge after release behaves as RUN.
REQ-025 SHALL with rst_n=0 and wait_cond=0 present PCWrite=1, IF_ID_Write=1, all other control outputs 0.

Configuration
REQ-026 SHALL, with HAZARD_PERF_EN defined, increment lu_stall_cnt per REQ-016 bubble cycle and flush_cnt per REQ-015 flush cycle, each saturating at 16'hFFFF.
REQ-027 SHALL, without HAZARD_PERF_EN, keep lu_stall_cnt and flush_cnt ports present and tied to 0, with no counter flops.

Verification
REQ-028 SHALL test load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_bubble=1; rd_EX=0 -> no bubble.
REQ-029 SHALL test rs2 gating: rd_EX=7, rs2_ID=7, uses_rs2_ID=0 -> no bubble; uses_rs2_ID=1 -> bubble.
REQ-030 SHALL test priority: branch_taken_EX=1 with load_use -> both flushes=1, bubble=0; add wait_cond -> pipe_freeze=1, flushes=0.
REQ-031 SHALL test memory wait: mem_req_MEM=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze high 3 cycles, low in 4th, state RUN, mem_timeout=0.
REQ-032 SHALL test timeout: wait_cond held 256 cycles -> mem_timeout=1 from cycle 257, stays 1 after mem_ready=1; rst_n=0 clears asynchronously.
REQ-033 SHALL test counters (HAZARD_PERF_EN): 3 bubbles, 2 flushes -> lu_stall_cnt=3, flush_cnt=2; preload saturated -> stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard controller: load-use stalls, branch squash, data-memory wait freeze and wait timeout.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_detection_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_EX,
  input  logic [4:0]  rd_EX,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        uses_rs2_ID,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERROR} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic        wait_cond;
  logic        load_use;
  logic [4:0]  src_id [2];
  logic [1:0]  src_used;
  logic [1:0]  src_hit;

  assign wait_cond = mem_req_MEM && !mem_ready;

  // Per-source match against the load destination; rs2 only counts when it is a real operand.
  assign src_id[0] = rs1_ID;
  assign src_id[1] = rs2_ID;
  assign src_used  = {uses_rs2_ID, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_id[gi] == rd_EX);
    end
  endgenerate

  assign load_use = MemRead_EX && (rd_EX != 5'd0) && (|src_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cond ? wait_cnt_reg + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN, ST_MEM_WAIT: begin
        if (wait_cond && (wait_cnt_reg == 8'hFF)) state_next = ST_ERROR;
        else if (wait_cond)                      state_next = ST_MEM_WAIT;
        else                                     state_next = ST_RUN;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RUN;
    endcase
  end

  // Priority: timeout error, then memory freeze, then branch squash, then load-use bubble.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    mem_timeout  = 1'b0;
    if (state_reg == ST_ERROR) begin
      pipe_freeze = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      mem_timeout = 1'b1;
    end else if (wait_cond) begin
      pipe_freeze = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (branch_taken_EX) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] lu_stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt_reg <= 16'd0;
      flush_cnt_reg    <= 16'd0;
    end else begin
      if (ID_EX_bubble && (lu_stall_cnt_reg != 16'hFFFF)) lu_stall_cnt_reg <= lu_stall_cnt_reg + 16'd1;
      if (IF_ID_flush && (flush_cnt_reg != 16'hFFFF))     flush_cnt_reg    <= flush_cnt_reg + 16'd1;
    end
  end

  assign lu_stall_cnt = lu_stall_cnt_reg;
  assign flush_cnt    = flush_cnt_reg;
`else
  assign lu_stall_cnt = 16'd0;
  assign flush_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed and randomized bench for hazard_detection_unit against a cycle-level behavioural model.
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MemRead_EX = 1'b0;
  logic [4:0]  rd_EX = 5'd0;
  logic [4:0]  rs1_ID = 5'd0;
  logic [4:0]  rs2_ID = 5'd0;
  logic        uses_rs2_ID = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic        mem_req_MEM = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IF_ID_Write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, pipe_freeze, mem_timeout;
  logic [15:0] lu_stall_cnt, flush_cnt;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_detection_unit dut (
    .clk(clk), .rst_n(rst_n), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs2_ID(uses_rs2_ID),
    .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive wait cycles seen, sticky timeout, whether last cycle was a wait.
  int          m_waits;
  bit          m_err;
  bit          m_prev_wait;
  logic [15:0] m_lu, m_fl;

  // Control vector order: PCWrite, IF_ID_Write, bubble, IF_ID_flush, ID_EX_flush, freeze, timeout
  function automatic logic [6:0] exp_ctrl();
    bit wc, lu;
    wc = mem_req_MEM && !mem_ready;
    lu = MemRead_EX && rd_EX != 0 && (rd_EX == rs1_ID || (uses_rs2_ID && rd_EX == rs2_ID));
    if (m_err)                  return 7'b0000011;
    if (wc)                     return 7'b0000010;
    if (!m_prev_wait && branch_taken_EX) return 7'b1101100;
    if (!m_prev_wait && lu)     return 7'b0010000;
    return 7'b1100000;
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {PCWrite, IF_ID_Write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, pipe_freeze, mem_timeout};
  endfunction

  task automatic model_reset();
    m_waits = 0; m_err = 0; m_prev_wait = 0; m_lu = 16'd0; m_fl = 16'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare mid-cycle, then advance the model at the rising edge.
  task automatic cycle(input string tag);
    logic [6:0] e;
    bit wc;
    @(negedge clk);
    e  = exp_ctrl();
    wc = mem_req_MEM && !mem_ready;
    check(tag, {25'd0, obs_ctrl()}, {25'd0, e});
    check({tag, "_cnt"}, {lu_stall_cnt, flush_cnt}, {m_lu, m_fl});
    @(posedge clk);
    if (PERF && e[4] && m_lu != 16'hFFFF) m_lu++;
    if (PERF && e[3] && m_fl != 16'hFFFF) m_fl++;
    if (!m_err) begin
      if (wc) begin
        m_waits++;
        if (m_waits == 256) m_err = 1;
      end else m_waits = 0;
    end
    m_prev_wait = wc;
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check({tag, "_async"}, {25'd0, obs_ctrl()}, {25'd0, exp_ctrl()});
    check({tag, "_async_cnt"}, {lu_stall_cnt, flush_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("step %s: reset applied", tag);
  endtask

  task automatic set_in(input bit mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input bit u2, input bit br, input bit req, input bit rdy);
    MemRead_EX = mr; rd_EX = rd; rs1_ID = r1; rs2_ID = r2;
    uses_rs2_ID = u2; branch_taken_EX = br; mem_req_MEM = req; mem_ready = rdy;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset("reset0");

    set_in(1, 5, 5, 0, 0, 0, 0, 0); cycle("lu_rs1");     $display("step lu_rs1 bubble=%b", ID_EX_bubble);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("lu_after");
    set_in(1, 0, 0, 0, 1, 0, 0, 0); cycle("lu_rd0");
    set_in(1, 7, 1, 7, 0, 0, 0, 0); cycle("rs2_unused");
    set_in(1, 7, 1, 7, 1, 0, 0, 0); cycle("rs2_used");   $display("step rs2 gating done");
    set_in(1, 5, 5, 0, 0, 1, 0, 0); cycle("br_over_lu");
    set_in(1, 5, 5, 0, 0, 1, 1, 0); cycle("freeze_over_br");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle("wait_ready"); $display("step priority done");

    // Three wait cycles, then ready; a load-use right after proves we are back in RUN.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cycle("memwait");
    mem_ready = 1'b1;           cycle("memwait_ready");
    set_in(1, 9, 9, 0, 0, 0, 0, 0); cycle("memwait_run_lu");
    check("memwait_timeout", {31'd0, mem_timeout}, 32'd0);
    $display("step memory wait done");

    do_reset("reset_cnt");
    repeat (3) begin
      set_in(1, 3, 0, 3, 1, 0, 0, 0); cycle("cnt_bubble");
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("cnt_idle");
    end
    repeat (2) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle("cnt_flush");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("cnt_idle2");
    check("cnt_lu_total", {16'd0, lu_stall_cnt}, PERF ? 32'd3 : 32'd0);
    check("cnt_fl_total", {16'd0, flush_cnt},    PERF ? 32'd2 : 32'd0);
    $display("step counters lu=%0d fl=%0d", lu_stall_cnt, flush_cnt);

`ifdef HAZARD_PERF_EN
    dut.lu_stall_cnt_reg = 16'hFFFE; dut.flush_cnt_reg = 16'hFFFE;
    m_lu = 16'hFFFE; m_fl = 16'hFFFE;
    repeat (3) begin
      set_in(1, 3, 3, 0, 0, 0, 0, 0); cycle("sat_bubble");
      set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle("sat_flush");
    end
    check("sat_lu", {16'd0, lu_stall_cnt}, 32'h0000FFFF);
    check("sat_fl", {16'd0, flush_cnt},    32'h0000FFFF);
    $display("step saturation done");
`endif

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
      cycle("random");
    end
    $display("step random done");

    do_reset("reset_to");
    set_in(1, 4, 4, 0, 0, 1, 1, 0);
    repeat (256) cycle("to_wait");
    check("to_cycle257", {31'd0, mem_timeout}, 32'd1);
    cycle("to_err");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle("to_ready");
    set_in(1, 2, 2, 0, 0, 1, 0, 0); repeat (3) cycle("to_sticky");
    $display("step timeout mem_timeout=%b", mem_timeout);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("reset_err");
    cycle("post_err_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
